fm_discriminator_axis: RTL and testbench
========================================

Name: fm_discriminator_axis

Overview:
- Parametrised FM discriminator for the receive chain's AXI-Stream path.
- Consumes per-sample phase words from the upstream CORDIC (angle in tdata[31:16]) and computes the wrap-correct signed phase difference between consecutive samples.
- Optionally accumulates DECIM differences per output (integrate-and-dump decimation), scales by an arithmetic right shift and saturates to OUT_W bits.
- Output goes to the audio filter/decimator stage; packet boundaries (tlast) are preserved.

Parameters:
C_S00_AXIS_TDATA_WIDTH, 32, input bus width; angle field occupies the top ANGLE_W bits.
C_M00_AXIS_TDATA_WIDTH, 32, output bus width; must be >= OUT_W.
ANGLE_W, 16, phase word width (unsigned, full scale = one turn).
DECIM, 1, differences summed per output beat; legal range 1..256.
SHIFT, 1, arithmetic right shift applied to the sum before saturation.
OUT_W, 16, signed result width placed in m00_axis_tdata[OUT_W-1:0].

Ports:
s00_axis_aclk  in  1  sole clock
s00_axis_aresetn  in  1  asynchronous active-low reset
s00_axis_tvalid  in  1  input beat valid
s00_axis_tready  out  1  input ready
s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  angle in [W-1 -: ANGLE_W]; other bits ignored
s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored
s00_axis_tlast  in  1  last beat of packet
m00_axis_tvalid  out  1  output beat valid
m00_axis_tready  in  1  downstream ready
m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  saturated result, sign-extended to the full bus width
m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid is high
m00_axis_tlast  out  1  end-of-packet marker
sat_pulse  out  1  one-cycle pulse when an emitted beat was clamped

Behaviour:
- Reset (asynchronous assert, synchronous release): m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tstrb=0, m00_axis_tlast=0, sat_pulse=0, prev angle=0, accumulator=0, decimation count=0, state=PRIME.
- A reset asserted mid-packet discards all partial state. No beat is emitted for the partial packet.
- Accept condition: s00_axis_tvalid && s00_axis_tready.
- s00_axis_tready = ~m00_axis_tvalid || m00_axis_tready. This gives a single output register with full throughput and no combinational path from tvalid to tready.
- Difference: d = (angle - prev) mod 2^ANGLE_W, interpreted as a signed ANGLE_W value.
  - 0x0010 after 0xFFF0 gives +0x20.
  - Exactly half a turn (0x8000) is interpreted as -2^(ANGLE_W-1).
- Accumulator width is ANGLE_W+8 signed, so it cannot overflow for DECIM <= 256.
- States:
  - PRIME: the first accepted beat after reset or after a tlast beat loads prev and emits nothing. Go to RUN. If this beat also has tlast=1, emit a zero beat with tlast=1 and stay in PRIME.
  - RUN: each accepted beat updates prev and adds d to acc. When count==DECIM-1, or when tlast=1, emit and then clear acc and count. Otherwise count++.
  - A tlast beat in RUN emits the partial sum with m00_axis_tlast=1 and returns to PRIME.
- Emit: r = (acc + d) >>> SHIFT, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_pulse=1 in the cycle tvalid rises if a clamp occurred.
  - m00_axis_tlast mirrors the tlast of the emitting beat.
- Latency: one clock from accepting the emitting beat to m00_axis_tvalid=1.
- Output data, tlast and tstrb are held stable while tvalid=1 && tready=0.
- tvalid clears on the downstream handshake unless a new emission is loaded in the same cycle. The handshake and a new load in the same cycle are legal; the new beat wins and tvalid stays 1.
- DECIM=1, SHIFT=0: the block is a plain wrap-correct differentiator, one output per input after priming.

Decomposition:
- Package fm_demod_pkg:
  - state enum {PRIME, RUN}
  - function wrap_diff(angle, prev) returning signed ANGLE_W
  - function sat_shift(acc, SHIFT, OUT_W) returning value plus clamp flag
  - localparam ACC_W = ANGLE_W+8
- Sub-module axis_out_reg: one-stage AXI-Stream output register (data, tlast, tstrb, valid/ready). It is reused by later chain stages.
- The top module holds the FSM, the prev register, the accumulator and the counter.

Test Plan:
- DECIM=1, SHIFT=0; angles 0x0000, 0x0100, 0x0300, 0x0200 -> outputs 0x00000100, 0x00000200, 0xFFFFFF00; first beat silent.
- Wrap: 0xFFF0 then 0x0010 -> 0x00000020. Then 0xFFF0 -> 0xFFFFFFE0. sat_pulse stays 0 throughout.
- DECIM=4, SHIFT=0; five angles stepping by 0x0100, then tlast on a 7th beat -> 0x00000400, then the partial 0x00000200 with tlast=1; PRIME is re-entered, and the next beat is silent.
- Saturation: DECIM=4, SHIFT=0, steps of +0x7000 -> 0x00007FFF with sat_pulse=1 for one cycle. Negative mirror -> 0xFFFF8000.
- Backpressure: hold m00_axis_tready=0 for 5 cycles with input streaming -> s00_axis_tready low after the first output is loaded, the output is held unchanged, no beats are lost, and the sequence resumes in order.
- Reset mid-packet (DECIM=4, after 2 beats) -> all outputs 0 immediately; the first post-reset beat is silent.

Source files
------------

// File: rtl/fm_demod_pkg.sv
`default_nettype none
//==============================================================================
// fm_demod_pkg - shared state type and wrap/saturate helpers | rev 1.0
//==============================================================================
package fm_demod_pkg;

  localparam int unsigned ANGLE_W_DEF = 16;
  localparam int unsigned ACC_W       = ANGLE_W_DEF + 8;
  // Helpers compute at a fixed width wide enough for any legal ANGLE_W/OUT_W.
  localparam int unsigned CALC_W      = 48;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic signed [CALC_W-1:0] val;
    logic                     clamp;
  } sat_t;

  function automatic logic signed [CALC_W-1:0] wrap_diff(
    input logic [CALC_W-1:0] angle,
    input logic [CALC_W-1:0] prev,
    input int unsigned       w
  );
    logic        [CALC_W-1:0] raw;
    logic signed [CALC_W-1:0] aligned;
    raw     = angle - prev;
    aligned = $signed(raw << (CALC_W - w));
    return aligned >>> (CALC_W - w);
  endfunction

  function automatic sat_t sat_shift(
    input logic signed [CALC_W-1:0] acc,
    input int unsigned              shift,
    input int unsigned              out_w
  );
    logic signed [CALC_W-1:0] shifted;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    sat_t                     res;
    shifted   = acc >>> shift;
    hi        = $signed((CALC_W'(1) << (out_w - 1)) - CALC_W'(1));
    lo        = ~hi;
    res.clamp = 1'b1;
    if (shifted > hi) begin
      res.val = hi;
    end else if (shifted < lo) begin
      res.val = lo;
    end else begin
      res.val   = shifted;
      res.clamp = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
//==============================================================================
// axis_out_reg - single-stage AXI-Stream output register, full throughput | rev 1.0
//==============================================================================
module axis_out_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_last_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_W-1:0]   m_data_o,
  output logic [DATA_W/8-1:0] m_strb_o,
  output logic                m_last_o
);

  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q;
  logic                last_q;

  assign s_ready_o = ~valid_q | m_ready_i;

  // A load in the same cycle as the downstream handshake replaces the beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else if (s_valid_i && s_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= s_data_i;
      strb_q  <= '1;
      last_q  <= s_last_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_strb_o  = strb_q;
  assign m_last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/fm_discriminator_axis.sv
`default_nettype none
//==============================================================================
// fm_discriminator_axis - wrap-correct phase differentiator with I&D decimation | rev 1.0
//==============================================================================
module fm_discriminator_axis
  import fm_demod_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ANGLE_W                = ANGLE_W_DEF,
  parameter int unsigned DECIM                  = 1,
  parameter int unsigned SHIFT                  = 1,
  parameter int unsigned OUT_W                  = 16
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic                                  sat_pulse
);

  localparam int unsigned SUM_W = ANGLE_W + 8;
  localparam int unsigned CNT_W = 9;

  state_e                             state_q;
  logic        [ANGLE_W-1:0]          prev_q;
  logic signed [SUM_W-1:0]            acc_q;
  logic        [CNT_W-1:0]            count_q;
  logic                               sat_q;

  logic        [ANGLE_W-1:0]          angle;
  logic signed [ANGLE_W-1:0]          diff;
  logic signed [SUM_W-1:0]            sum;
  sat_t                               sat_res;
  logic                               accept;
  logic                               last_chunk;
  logic                               emit;
  logic                               clamp;
  logic        [C_M00_AXIS_TDATA_WIDTH-1:0] emit_data;
  logic                               unused_sink;

  assign angle      = s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1 -: ANGLE_W];
  assign diff       = ANGLE_W'(wrap_diff(CALC_W'(angle), CALC_W'(prev_q), ANGLE_W));
  assign sum        = acc_q + SUM_W'(diff);
  assign sat_res    = sat_shift(CALC_W'(sum), SHIFT, OUT_W);
  assign accept     = s00_axis_tvalid && s00_axis_tready;
  assign last_chunk = (count_q == CNT_W'(DECIM - 1));
  assign emit       = accept && ((state_q == PRIME) ? s00_axis_tlast
                                                    : (s00_axis_tlast || last_chunk));
  // A one-beat packet has no difference to report, so it carries a zero.
  assign emit_data  = (state_q == PRIME) ? '0 : C_M00_AXIS_TDATA_WIDTH'($signed(sat_res.val));
  assign clamp      = (state_q == RUN) && sat_res.clamp;
  assign unused_sink = ^{s00_axis_tstrb, s00_axis_tdata, sat_res.val, sat_res.clamp};

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q <= PRIME;
      prev_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      sat_q <= emit && clamp;
      if (accept) begin
        prev_q <= angle;
        if (state_q == PRIME) begin
          acc_q   <= '0;
          count_q <= '0;
          if (!s00_axis_tlast) state_q <= RUN;
        end else if (emit) begin
          acc_q   <= '0;
          count_q <= '0;
          if (s00_axis_tlast) state_q <= PRIME;
        end else begin
          acc_q   <= sum;
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  axis_out_reg #(
    .DATA_W (C_M00_AXIS_TDATA_WIDTH)
  ) u_out (
    .clk_i     (s00_axis_aclk),
    .rst_ni    (s00_axis_aresetn),
    .s_valid_i (emit),
    .s_ready_o (s00_axis_tready),
    .s_data_i  (emit_data),
    .s_last_i  (s00_axis_tlast),
    .m_valid_o (m00_axis_tvalid),
    .m_ready_i (m00_axis_tready),
    .m_data_o  (m00_axis_tdata),
    .m_strb_o  (m00_axis_tstrb),
    .m_last_o  (m00_axis_tlast)
  );

  assign sat_pulse = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_discriminator_axis.sv
`default_nettype none
//==============================================================================
// tb_fm_discriminator_axis - three configurations checked against a packet model | rev 1.0
//==============================================================================
module tb_fm_discriminator_axis;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        s_tvalid [NI];
  logic        s_tready [NI];
  logic [31:0] s_tdata  [NI];
  logic        s_tlast  [NI];
  logic        m_tvalid [NI];
  logic        m_tready [NI];
  logic [31:0] m_tdata  [NI];
  logic [3:0]  m_tstrb  [NI];
  logic        m_tlast  [NI];
  logic        sat      [NI];

  fm_discriminator_axis #(.DECIM(1), .SHIFT(0)) u_d1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid[0]), .s00_axis_tready(s_tready[0]),
    .s00_axis_tdata(s_tdata[0]), .s00_axis_tstrb(4'hF), .s00_axis_tlast(s_tlast[0]),
    .m00_axis_tvalid(m_tvalid[0]), .m00_axis_tready(m_tready[0]),
    .m00_axis_tdata(m_tdata[0]), .m00_axis_tstrb(m_tstrb[0]), .m00_axis_tlast(m_tlast[0]),
    .sat_pulse(sat[0]));

  fm_discriminator_axis #(.DECIM(4), .SHIFT(0)) u_d4 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid[1]), .s00_axis_tready(s_tready[1]),
    .s00_axis_tdata(s_tdata[1]), .s00_axis_tstrb(4'hF), .s00_axis_tlast(s_tlast[1]),
    .m00_axis_tvalid(m_tvalid[1]), .m00_axis_tready(m_tready[1]),
    .m00_axis_tdata(m_tdata[1]), .m00_axis_tstrb(m_tstrb[1]), .m00_axis_tlast(m_tlast[1]),
    .sat_pulse(sat[1]));

  fm_discriminator_axis #(.DECIM(2), .SHIFT(1)) u_d2s1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid[2]), .s00_axis_tready(s_tready[2]),
    .s00_axis_tdata(s_tdata[2]), .s00_axis_tstrb(4'hF), .s00_axis_tlast(s_tlast[2]),
    .m00_axis_tvalid(m_tvalid[2]), .m00_axis_tready(m_tready[2]),
    .m00_axis_tdata(m_tdata[2]), .m00_axis_tstrb(m_tstrb[2]), .m00_axis_tlast(m_tlast[2]),
    .sat_pulse(sat[2]));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: packet beats per instance, expected beats as a ring buffer.
  int pkt   [NI][64];
  int pkt_n [NI];
  int exp_d [NI][64];
  bit exp_l [NI][64];
  bit exp_c [NI][64];
  int wr    [NI];
  int rd    [NI];

  int log_d [NI][16];
  bit log_l [NI][16];
  bit log_s [NI][16];
  int log_n [NI];

  logic [31:0] d_prev  [NI];
  bit          l_prev  [NI];
  bit          v_prev  [NI];
  bit          hs_prev [NI];
  bit          mon_hs, mon_nb, mon_ec;

  function automatic int dec_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 2;
  endfunction

  function automatic int sh_of(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int wrap16(int x);
    int v;
    v = x & 65535;
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(int k, int d, bit l, bit c);
    exp_d[k][wr[k] % 64] = d;
    exp_l[k][wr[k] % 64] = l;
    exp_c[k][wr[k] % 64] = c;
    wr[k]++;
  endtask

  // Each output is the floor-shifted sum of the per-sample wrapped
  // differences of its DECIM-sized chunk (or the remainder at end of packet).
  task automatic model_accept(int k, int ang, bit last);
    int n, cnt, sum, r;
    bit c;
    if (pkt_n[k] < 64) begin
      pkt[k][pkt_n[k]] = ang;
      pkt_n[k]++;
    end
    n = pkt_n[k];
    if (n == 1) begin
      if (last) push(k, 0, 1'b1, 1'b0);
    end else if ((((n - 1) % dec_of(k)) == 0) || last) begin
      cnt = (n - 1) % dec_of(k);
      if (cnt == 0) cnt = dec_of(k);
      sum = 0;
      for (int i = n - cnt; i < n; i++) sum += wrap16(pkt[k][i] - pkt[k][i-1]);
      r = sum >>> sh_of(k);
      c = 1'b0;
      if (r > 32767) begin
        r = 32767; c = 1'b1;
      end else if (r < -32768) begin
        r = -32768; c = 1'b1;
      end
      push(k, r, last, c);
    end
    if (last) pkt_n[k] = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        v_prev[k] = 1'b0; hs_prev[k] = 1'b0; rd[k] = wr[k]; pkt_n[k] = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        mon_hs = m_tvalid[k] && m_tready[k];
        mon_nb = m_tvalid[k] && (!v_prev[k] || hs_prev[k]);
        mon_ec = 1'b0;
        chk($sformatf("tready_rule%0d", k), 32'(s_tready[k]), 32'(!m_tvalid[k] || m_tready[k]));
        if (m_tvalid[k]) chk($sformatf("tstrb%0d", k), 32'(m_tstrb[k]), 32'hF);
        if (v_prev[k] && !hs_prev[k]) begin
          chk($sformatf("hold_valid%0d", k), 32'(m_tvalid[k]), 32'd1);
          chk($sformatf("hold_data%0d", k), m_tdata[k], d_prev[k]);
          chk($sformatf("hold_last%0d", k), 32'(m_tlast[k]), 32'(l_prev[k]));
        end
        if (mon_nb) begin
          if (rd[k] == wr[k]) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat%0d: got %h, expected no beat at %0t", k, m_tdata[k], $time);
          end else begin
            chk($sformatf("data%0d", k), m_tdata[k], 32'(exp_d[k][rd[k] % 64]));
            chk($sformatf("last%0d", k), 32'(m_tlast[k]), 32'(exp_l[k][rd[k] % 64]));
            mon_ec = exp_c[k][rd[k] % 64];
            rd[k]++;
          end
          if (log_n[k] < 16) begin
            log_d[k][log_n[k]] = int'(m_tdata[k]);
            log_l[k][log_n[k]] = m_tlast[k];
            log_s[k][log_n[k]] = sat[k];
          end
          log_n[k]++;
        end
        chk($sformatf("sat_pulse%0d", k), 32'(sat[k]), 32'(mon_ec));
        if (s_tvalid[k] && s_tready[k]) model_accept(k, int'(s_tdata[k][31:16]), s_tlast[k]);
        v_prev[k]  = m_tvalid[k];
        hs_prev[k] = mon_hs;
        d_prev[k]  = m_tdata[k];
        l_prev[k]  = m_tlast[k];
      end
    end
  end

  task automatic send(int k, int ang, bit last);
    bit ok;
    int t;
    s_tdata[k]  = 32'(ang) << 16;
    s_tlast[k]  = last;
    s_tvalid[k] = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = s_tready[k];
      @(posedge clk);
      #1;
      t++;
    end
    s_tvalid[k] = 1'b0;
    s_tlast[k]  = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout%0d: got no tready, expected tready within 50 cycles", k);
    end
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk($sformatf("drained%0d", k), 32'(wr[k] - rd[k]), 32'd0);
  endtask

  task automatic chk_log(int k, int i, logic [31:0] d, bit l, bit s);
    chk($sformatf("lit_data%0d_%0d", k, i), 32'(log_d[k][i]), d);
    chk($sformatf("lit_last%0d_%0d", k, i), 32'(log_l[k][i]), 32'(l));
    chk($sformatf("lit_sat%0d_%0d", k, i), 32'(log_s[k][i]), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      s_tvalid[k] = 1'b0; s_tdata[k] = '0; s_tlast[k] = 1'b0; m_tready[k] = 1'b1;
      wr[k] = 0; rd[k] = 0; pkt_n[k] = 0; log_n[k] = 0;
      v_prev[k] = 1'b0; hs_prev[k] = 1'b0; d_prev[k] = '0; l_prev[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(m_tvalid[k]), 32'd0);
      chk($sformatf("rst_data%0d", k), m_tdata[k], 32'd0);
      chk($sformatf("rst_strb%0d", k), 32'(m_tstrb[k]), 32'd0);
      chk($sformatf("rst_last%0d", k), 32'(m_tlast[k]), 32'd0);
      chk($sformatf("rst_sat%0d", k), 32'(sat[k]), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain differentiator, wrap, half-turn and one-beat packet.
    send(0, 'h0000, 0); send(0, 'h0100, 0); send(0, 'h0300, 0); send(0, 'h0200, 1);
    send(0, 'hFFF0, 0); send(0, 'h0010, 0); send(0, 'hFFF0, 1);
    send(0, 'h0000, 0); send(0, 'h8000, 1);
    send(0, 'h1234, 1);
    // Decimate by 4: full chunk, partial, positive and negative clamp.
    for (int i = 0; i < 7; i++) send(1, i * 'h100, (i == 6));
    send(1, 'h0000, 0); send(1, 'h7000, 0); send(1, 'hE000, 0);
    send(1, 'h5000, 0); send(1, 'hC000, 0); send(1, 'h3000, 1);
    send(1, 'h0000, 0); send(1, 'h9000, 0); send(1, 'h2000, 0);
    send(1, 'hB000, 0); send(1, 'h4000, 1);
    // Decimate by 2 with shift 1, including floor of a negative odd sum.
    send(2, 'h0000, 0); send(2, 'h0100, 0); send(2, 'h0300, 1);
    send(2, 'h0000, 0); send(2, 'hFFFF, 0); send(2, 'hFFFD, 1);
    drain();
    chk("count0", 32'(log_n[0]), 32'd7);
    chk_log(0, 0, 32'h00000100, 0, 0);
    chk_log(0, 1, 32'h00000200, 0, 0);
    chk_log(0, 2, 32'hFFFFFF00, 1, 0);
    chk_log(0, 3, 32'h00000020, 0, 0);
    chk_log(0, 4, 32'hFFFFFFE0, 1, 0);
    chk_log(0, 5, 32'hFFFF8000, 1, 0);
    chk_log(0, 6, 32'h00000000, 1, 0);
    chk("count1", 32'(log_n[1]), 32'd5);
    chk_log(1, 0, 32'h00000400, 0, 0);
    chk_log(1, 1, 32'h00000200, 1, 0);
    chk_log(1, 2, 32'h00007FFF, 0, 1);
    chk_log(1, 3, 32'h00007000, 1, 0);
    chk_log(1, 4, 32'hFFFF8000, 1, 1);
    chk("count2", 32'(log_n[2]), 32'd2);
    chk_log(2, 0, 32'h00000180, 1, 0);
    chk_log(2, 1, 32'hFFFFFFFE, 1, 0);

    // Backpressure: five stalled cycles while the input keeps streaming.
    log_n[0] = 0;
    fork
      begin
        send(0, 'h0000, 0); send(0, 'h0010, 0); send(0, 'h0030, 0); send(0, 'h0060, 0);
        send(0, 'h00A0, 0); send(0, 'h00F0, 0); send(0, 'h0150, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_tready[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_tready", 32'(s_tready[0]), 32'd0);
        chk("stall_valid", 32'(m_tvalid[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1 m_tready[0] = 1'b1;
      end
    join
    drain();
    chk("count_bp", 32'(log_n[0]), 32'd6);
    for (int i = 0; i < 6; i++) chk_log(0, i, 32'((i + 1) * 'h10), (i == 5), 0);

    // Reset mid-packet with a held output beat on the first instance.
    m_tready[0] = 1'b0;
    send(0, 'h0100, 0); send(0, 'h0200, 0);
    send(1, 'h1000, 0); send(1, 'h2000, 0);
    chk("pre_rst_valid", 32'(m_tvalid[0]), 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid0", 32'(m_tvalid[0]), 32'd0);
    chk("mid_rst_data0", m_tdata[0], 32'd0);
    chk("mid_rst_strb0", 32'(m_tstrb[0]), 32'd0);
    chk("mid_rst_valid1", 32'(m_tvalid[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_tready[0] = 1'b1;
    log_n[1] = 0;
    send(1, 'h0100, 0); send(1, 'h0300, 1);
    drain();
    chk("count_rst", 32'(log_n[1]), 32'd1);
    chk_log(1, 0, 32'h00000200, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
